// File: rtl/audio_pkg.sv
// audio_pkg: shared scheduler state type, channel encodings and control-word bit indices
package audio_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_t;
    localparam logic CHAN_L = 1'b1;
    localparam logic CHAN_R = 1'b0;
    localparam int FEEDBACK_BIT_IDX = 0;
    localparam int ENABLE_BIT_IDX = 1;
endpackage

// File: rtl/audio_chan_slot.sv
// audio_chan_slot: per-channel capture/result buffering with sticky overrun/underrun
//   cap_i/din_i   : capture strobe and sample from the codec
//   take_i        : scheduler dispatched this channel's pending sample
//   wr_i/res_i    : result write from the scheduler
//   req_i         : codec output request; clr_i clears sticky flags
//   pend_o/cap_o  : pending flag and captured sample; out_o drives the codec
module audio_chan_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cap_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             take_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic             req_i,
    input  logic             clr_i,
    output logic             pend_o,
    output logic [WIDTH-1:0] cap_o,
    output logic [WIDTH-1:0] out_o,
    output logic             overrun_o,
    output logic             underrun_o
);
    logic             pend_q, pend_d, fresh_q, fresh_d, ov_q, ov_d, un_q, un_d;
    logic [WIDTH-1:0] cap_q, cap_d, res_q, res_d, out_q, out_d;
    always_comb begin
        pend_d  = cap_i | (pend_q & ~take_i);
        cap_d   = cap_i ? din_i : cap_q;
        res_d   = wr_i ? res_i : res_q;
        fresh_d = wr_i | (fresh_q & ~req_i);
        out_d   = (req_i & fresh_q) ? res_q : out_q;
        // a capture coinciding with dispatch loses nothing, so it is not an overrun
        ov_d    = (cap_i & pend_q & ~take_i) | (ov_q & ~clr_i);
        un_d    = (req_i & ~fresh_q) | (un_q & ~clr_i);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= 1'b0;
            fresh_q <= 1'b0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            cap_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            fresh_q <= fresh_d;
            ov_q    <= ov_d;
            un_q    <= un_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
            out_q   <= out_d;
        end
    end
    assign pend_o     = pend_q;
    assign cap_o      = cap_q;
    assign out_o      = out_q;
    assign overrun_o  = ov_q;
    assign underrun_o = un_q;
endmodule

// File: rtl/audio_effect_scheduler.sv
// audio_effect_scheduler: shares one effect engine between left/right codec channels
//   codec side : sample_end/audio_input_* capture, sample_req/audio_output_* playback
//   control    : control_in/control_wr shadow, copied to eng_control at left dispatch
//   engine     : eng_valid/eng_ready job handshake, res_valid/res_data result
//   status     : sticky overrun/underrun/timeout, cleared by status_clr
module audio_effect_scheduler
    import audio_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int TIMEOUT    = 255,
    parameter int ENABLE_BIT = ENABLE_BIT_IDX
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       sample_end,
    input  logic [1:0]       sample_req,
    input  logic [WIDTH-1:0] audio_input_l,
    input  logic [WIDTH-1:0] audio_input_r,
    output logic [WIDTH-1:0] audio_output_l,
    output logic [WIDTH-1:0] audio_output_r,
    input  logic [3:0]       control_in,
    input  logic             control_wr,
    output logic             eng_valid,
    input  logic             eng_ready,
    output logic             eng_chan,
    output logic [WIDTH-1:0] eng_data,
    output logic [3:0]       eng_control,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    input  logic             status_clr,
    output logic [1:0]       overrun,
    output logic [1:0]       underrun,
    output logic             timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    sched_state_t     state_q, state_d;
    logic             last_q, last_d, job_chan_q, job_chan_d, to_q, to_d;
    logic [WIDTH-1:0] job_data_q, job_data_d, cap_l, cap_r, wr_data;
    logic [3:0]       shadow_q, act_q, act_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             pend_l, pend_r, sel, take, wr, wr_chan, to_set;
    // round-robin: with both pending, serve the channel not served last
    assign sel     = (pend_l & pend_r) ? ~last_q : pend_l;
    assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        job_chan_d = job_chan_q;
        job_data_d = job_data_q;
        act_d      = act_q;
        cnt_d      = cnt_q;
        take       = 1'b0;
        wr         = 1'b0;
        wr_chan    = job_chan_q;
        wr_data    = '0;
        to_set     = 1'b0;
        case (state_q)
            IDLE: if (pend_l | pend_r) begin
                take       = 1'b1;
                last_d     = sel;
                job_chan_d = sel;
                job_data_d = (sel == CHAN_L) ? cap_l : cap_r;
                act_d      = (sel == CHAN_L) ? shadow_q : act_q;
                wr_chan    = sel;
                cnt_d      = '0;
                // bypass writes a zero result without touching the engine
                if (act_d[ENABLE_BIT]) state_d = ISSUE;
                else wr = 1'b1;
            end
            ISSUE: if (eng_ready) state_d = WAIT;
            WAIT: begin
                cnt_d = cnt_inc;
                if (res_valid) begin
                    wr      = 1'b1;
                    wr_data = res_data;
                    state_d = IDLE;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    wr      = 1'b1;
                    wr_data = job_data_q;
                    to_set  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        to_d = to_set | (to_q & ~status_clr);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= CHAN_R;
            job_chan_q <= 1'b0;
            job_data_q <= '0;
            shadow_q   <= '0;
            act_q      <= '0;
            cnt_q      <= '0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            job_chan_q <= job_chan_d;
            job_data_q <= job_data_d;
            shadow_q   <= control_wr ? control_in : shadow_q;
            act_q      <= act_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
        end
    end
    audio_chan_slot #(.WIDTH(WIDTH)) u_slot_l (
        .clk        (clk),
        .reset_n    (reset_n),
        .cap_i      (sample_end[1]),
        .din_i      (audio_input_l),
        .take_i     (take & (sel == CHAN_L)),
        .wr_i       (wr & (wr_chan == CHAN_L)),
        .res_i      (wr_data),
        .req_i      (sample_req[1]),
        .clr_i      (status_clr),
        .pend_o     (pend_l),
        .cap_o      (cap_l),
        .out_o      (audio_output_l),
        .overrun_o  (overrun[1]),
        .underrun_o (underrun[1])
    );
    audio_chan_slot #(.WIDTH(WIDTH)) u_slot_r (
        .clk        (clk),
        .reset_n    (reset_n),
        .cap_i      (sample_end[0]),
        .din_i      (audio_input_r),
        .take_i     (take & (sel == CHAN_R)),
        .wr_i       (wr & (wr_chan == CHAN_R)),
        .res_i      (wr_data),
        .req_i      (sample_req[0]),
        .clr_i      (status_clr),
        .pend_o     (pend_r),
        .cap_o      (cap_r),
        .out_o      (audio_output_r),
        .overrun_o  (overrun[0]),
        .underrun_o (underrun[0])
    );
    assign eng_valid   = (state_q == ISSUE);
    assign eng_chan    = job_chan_q;
    assign eng_data    = job_data_q;
    assign eng_control = act_q;
    assign timeout     = to_q;
endmodule

// File: tb/tb_audio_effect_scheduler.sv
// tb_audio_effect_scheduler: directed scoreboard bench with an echo-plus-one engine model
module tb_audio_effect_scheduler;
    localparam int W = 16;
    logic         clk = 1'b0, reset_n = 1'b0;
    logic [1:0]   sample_end = '0, sample_req = '0;
    logic [W-1:0] audio_input_l = '0, audio_input_r = '0;
    logic [W-1:0] audio_output_l, audio_output_r;
    logic [3:0]   control_in = '0;
    logic         control_wr = 1'b0;
    logic         eng_valid, eng_chan;
    logic         eng_ready = 1'b1;
    logic [W-1:0] eng_data;
    logic [3:0]   eng_control;
    logic         res_valid = 1'b0;
    logic [W-1:0] res_data = '0;
    logic         status_clr = 1'b0;
    logic [1:0]   overrun, underrun;
    logic         timeout;
    int           errors = 0, checks = 0, hs_count = 0, snap;
    logic [W:0]   exp_job[$];
    logic [W-1:0] exp_l[$], exp_r[$];
    logic         echo_en = 1'b1;

    audio_effect_scheduler #(.WIDTH(W), .TIMEOUT(255), .ENABLE_BIT(1)) dut (
        .clk(clk), .reset_n(reset_n), .sample_end(sample_end), .sample_req(sample_req),
        .audio_input_l(audio_input_l), .audio_input_r(audio_input_r),
        .audio_output_l(audio_output_l), .audio_output_r(audio_output_r),
        .control_in(control_in), .control_wr(control_wr),
        .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_chan(eng_chan),
        .eng_data(eng_data), .eng_control(eng_control),
        .res_valid(res_valid), .res_data(res_data), .status_clr(status_clr),
        .overrun(overrun), .underrun(underrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // engine model: checks each accepted job against the scoreboard and
    // returns data+1 a few cycles later while echo_en is set
    initial begin
        logic [W:0]   pipe [3];
        logic         hs;
        logic [W-1:0] hd;
        logic [W:0]   e;
        pipe = '{default: '0};
        forever begin
            @(negedge clk);
            hs = reset_n && eng_valid && eng_ready;
            hd = eng_data;
            if (hs) begin
                hs_count++;
                chk("job_expected", 32'(exp_job.size() != 0), 32'd1);
                if (exp_job.size() != 0) begin
                    e = exp_job.pop_front();
                    chk("job_chan_data", {15'd0, eng_chan, eng_data}, {15'd0, e});
                end
            end
            @(posedge clk);
            #1;
            res_valid = pipe[2][W] & echo_en;
            res_data  = pipe[2][W-1:0];
            pipe[2]   = pipe[1];
            pipe[1]   = pipe[0];
            pipe[0]   = {hs, hd + 16'd1};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [1:0] se, input logic [W-1:0] l, input logic [W-1:0] r);
        audio_input_l = l;
        audio_input_r = r;
        sample_end = se;
        tick(1);
        sample_end = '0;
    endtask

    task automatic wr_ctl(input logic [3:0] c);
        control_in = c;
        control_wr = 1'b1;
        tick(1);
        control_wr = 1'b0;
    endtask

    task automatic clr();
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
    endtask

    task automatic req_chk(input logic left);
        logic [W-1:0] e;
        sample_req = left ? 2'b10 : 2'b01;
        tick(1);
        sample_req = '0;
        if (left) begin
            e = (exp_l.size() != 0) ? exp_l.pop_front() : 'x;
            chk("audio_output_l", {16'd0, audio_output_l}, {16'd0, e});
        end else begin
            e = (exp_r.size() != 0) ? exp_r.pop_front() : 'x;
            chk("audio_output_r", {16'd0, audio_output_r}, {16'd0, e});
        end
    endtask

    initial begin
        tick(3);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_eng_data", eng_data, 0);
        chk("rst_eng_control", eng_control, 0);
        chk("rst_out_l", audio_output_l, 0);
        chk("rst_out_r", audio_output_r, 0);
        chk("rst_flags", {overrun, underrun, timeout}, 0);
        reset_n = 1'b1;
        tick(1);
        wr_ctl(4'b0010);

        // simultaneous capture: left first after reset, then right
        exp_job.push_back({1'b1, 16'h0010});
        exp_job.push_back({1'b0, 16'h0020});
        exp_l.push_back(16'h0011);
        exp_r.push_back(16'h0021);
        cap(2'b11, 16'h0010, 16'h0020);
        tick(30);
        chk("sim_jobs_drained", exp_job.size(), 0);
        req_chk(1'b1);
        req_chk(1'b0);

        // basic path and dispatch latency
        exp_job.push_back({1'b1, 16'h1234});
        exp_l.push_back(16'h1235);
        cap(2'b10, 16'h1234, 16'h0);
        @(negedge clk);
        chk("latency_cycle1_valid", eng_valid, 0);
        @(negedge clk);
        chk("latency_cycle2_valid", eng_valid, 1);
        chk("basic_eng_chan", eng_chan, 1);
        chk("basic_eng_data", eng_data, 16'h1234);
        chk("basic_eng_control", eng_control, 4'b0010);
        tick(20);
        req_chk(1'b1);
        chk("basic_no_flags", {overrun, underrun, timeout}, 0);

        // overrun under backpressure: left job stalls, right recaptured twice
        eng_ready = 1'b0;
        exp_job.push_back({1'b1, 16'h0555});
        exp_job.push_back({1'b0, 16'hBBBB});
        exp_l.push_back(16'h0556);
        exp_r.push_back(16'hBBBC);
        cap(2'b10, 16'h0555, 16'h0);
        tick(3);
        cap(2'b01, 16'h0, 16'hAAAA);
        cap(2'b01, 16'h0, 16'hBBBB);
        @(negedge clk);
        chk("stall_valid_held", eng_valid, 1);
        chk("overrun_r", overrun, 2'b01);
        eng_ready = 1'b1;
        tick(40);
        chk("ovr_jobs_drained", exp_job.size(), 0);
        req_chk(1'b1);
        req_chk(1'b0);
        clr();
        chk("overrun_cleared", overrun, 0);

        // timeout: engine silent, captured sample passes through
        echo_en = 1'b0;
        exp_job.push_back({1'b0, 16'h1357});
        exp_r.push_back(16'h1357);
        cap(2'b01, 16'h0, 16'h1357);
        tick(200);
        chk("timeout_not_yet", timeout, 0);
        tick(70);
        chk("timeout_set", timeout, 1);
        req_chk(1'b0);
        clr();
        chk("timeout_cleared", timeout, 0);
        echo_en = 1'b1;

        // control change between left and right dispatch
        exp_job.push_back({1'b1, 16'h4000});
        exp_job.push_back({1'b0, 16'h4001});
        exp_l.push_back(16'h4001);
        exp_r.push_back(16'h4002);
        cap(2'b10, 16'h4000, 16'h0);
        tick(1);
        wr_ctl(4'b0000);
        cap(2'b01, 16'h0, 16'h4001);
        tick(40);
        chk("ctl_jobs_drained", exp_job.size(), 0);
        req_chk(1'b1);
        req_chk(1'b0);

        // next frame bypasses the engine
        snap = hs_count;
        exp_l.push_back(16'h0000);
        exp_r.push_back(16'h0000);
        cap(2'b11, 16'h5555, 16'h6666);
        tick(10);
        chk("bypass_no_handshake", hs_count, snap);
        chk("bypass_eng_control", eng_control, 0);
        req_chk(1'b1);
        req_chk(1'b0);

        // asynchronous reset in the middle of a WAIT
        wr_ctl(4'b0010);
        echo_en = 1'b0;
        exp_job.push_back({1'b1, 16'h7777});
        cap(2'b10, 16'h7777, 16'h0);
        tick(5);
        chk("pre_reset_eng_data", eng_data, 16'h7777);
        chk("pre_reset_eng_control", eng_control, 4'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_eng_valid", eng_valid, 0);
        chk("midreset_eng_data", eng_data, 0);
        chk("midreset_eng_control", eng_control, 0);
        chk("midreset_eng_chan", eng_chan, 0);
        tick(2);
        reset_n = 1'b1;
        echo_en = 1'b1;
        tick(2);

        // underrun: request with no fresh result keeps the old output
        sample_req = 2'b10;
        tick(1);
        sample_req = '0;
        chk("underrun_out_l", audio_output_l, 0);
        chk("underrun_flag", underrun, 2'b10);
        clr();
        chk("underrun_cleared", underrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_effect_scheduler.md
Name: audio_effect_scheduler

Overview:
- Shares one external effect engine (gain/filter pipeline) between the left and right codec channels.
- Captures codec samples on the sample_end strobes and dispatches them one at a time to the engine over a valid/ready handshake.
- Collects engine results and presents them to the codec on the sample_req strobes.
- Double-buffers the 4-bit effect control word so that the left and right samples of one frame always use the same settings.

Parameters:
- WIDTH, 16, sample width in bits.
- TIMEOUT, 255, maximum number of cycles to wait for res_valid before a job is aborted.
- ENABLE_BIT, 1, index of the control bit that routes samples through the engine.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sample_end  in  2  capture strobes: bit1 = left, bit0 = right
- sample_req  in  2  codec output request strobes: bit1 = left, bit0 = right
- audio_input_l  in  WIDTH  left sample from codec
- audio_input_r  in  WIDTH  right sample from codec
- audio_output_l  out  WIDTH  left sample to codec
- audio_output_r  out  WIDTH  right sample to codec
- control_in  in  4  new control word
- control_wr  in  1  one-cycle pulse that loads control_in into the shadow register
- eng_valid  out  1  job offered to the engine
- eng_ready  in  1  engine accepts the job
- eng_chan  out  1  channel of the job: 1 = left, 0 = right
- eng_data  out  WIDTH  sample of the job
- eng_control  out  4  active control word
- res_valid  in  1  engine result valid
- res_data  in  WIDTH  engine result
- status_clr  in  1  one-cycle pulse that clears the sticky flags
- overrun  out  2  sticky: a new capture arrived while that channel was still pending
- underrun  out  2  sticky: sample_req arrived with no fresh result for that channel
- timeout  out  1  sticky: an engine job was aborted

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs 0, state IDLE, pending/fresh flags cleared.
  - Shadow and active control registers = 0.
  - Takes effect mid-job too; the engine sees eng_valid drop immediately.
- Capture:
  - sample_end[1] sets pend_l and latches audio_input_l into cap_l; sample_end[0] does the same for the right channel. Both may occur in the same cycle.
  - A capture on a channel that is already pending replaces the captured sample and sets the matching overrun bit.
  - A captured sample is never dropped while it is in flight.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE with any pending channel: select a channel round-robin, alternating from the last channel served; left wins after reset. Clear its pend flag.
    - If the left channel is selected, copy the shadow control word into the active control word.
    - If active[ENABLE_BIT] = 0: write result 0 for that channel, set fresh, stay in IDLE (bypass; the engine is untouched).
    - Otherwise go to ISSUE.
  - ISSUE: eng_valid = 1; eng_chan, eng_data and eng_control are held stable. Go to WAIT on the cycle eng_valid && eng_ready.
  - WAIT: eng_valid = 0 and the wait counter increments.
    - res_valid: latch res_data into res_l or res_r, set fresh, go to IDLE.
    - Counter reaches TIMEOUT: latch the captured sample unchanged (pass-through), set fresh and timeout, go to IDLE.
    - A res_valid arriving in any other state is ignored.
- Latency: a sample_end pulse in cycle 0 with the FSM in IDLE gives eng_valid = 1 in cycle 2.
- Output:
  - sample_req[1]: audio_output_l <= res_l and fresh_l is cleared. If fresh_l was already 0, the previous value is kept (res_l is not re-sampled) and underrun[1] is set. sample_req[0] does the same for the right channel.
  - Outputs change only on a sample_req edge.
- Control:
  - control_wr loads the shadow register in 1 cycle; the last write wins.
  - The active control word changes only at a left-channel dispatch.
- status_clr clears overrun, underrun and timeout. A set event in the same cycle takes priority over the clear.
- Width: no arithmetic in the datapath; samples pass through unmodified. The wait counter is clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Package audio_pkg holds:
  - sched_state_t enum {IDLE, ISSUE, WAIT}
  - CHAN_L = 1, CHAN_R = 0
  - FEEDBACK / ENABLE bit-index constants, shared with the effect datapath.
- One natural sub-module, audio_chan_slot (instantiated twice, once per channel): pending flag, capture register, result register, fresh flag, overrun and underrun logic. The FSM and arbiter stay in the top level.

Test Plan:
- Basic path: enable bit set, engine echoes data+1 with 3-cycle latency. sample_end=2'b10 with input_l=16'h1234 -> eng_valid in cycle 2 with eng_chan=1 and eng_data=16'h1234. A later sample_req[1] -> audio_output_l = 16'h1235; no sticky flags set.
- Simultaneous capture: sample_end=2'b11 with L=16'h0010, R=16'h0020 -> left job issued first, then right. Results reach audio_output_l/r after their respective sample_req pulses.
- Overrun and backpressure: hold eng_ready=0 and send two sample_end[0] pulses (16'hAAAA then 16'hBBBB) -> overrun=2'b01. After ready rises, the job carries 16'hBBBB.
- Timeout: engine never asserts res_valid -> after 255 WAIT cycles, timeout=1 and audio_output_r = the captured input on the next sample_req[0].
- Control and bypass: write control=4'b0000 mid-frame, between the left and right dispatch -> the right sample still uses the old word. The next frame bypasses the engine (eng_valid stays 0) and outputs 16'h0000.
- Reset and underrun: assert reset_n=0 during WAIT -> all outputs 0 immediately. After release, sample_req[1] with no capture -> output stays 0 and underrun=2'b10; status_clr clears it.
